// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: stage indices and controller FSM states.
package riscv_pipe_pkg;

  // Stage indices; stages at STG_WB and above are writeback/retire.
  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } pipe_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: decode reads a register that the load in execute
// has not yet produced. Register x0 never creates a hazard.
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  id_valid,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic                  dec_use_rs1,
  input  logic                  dec_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_read_mem,
  output logic                  loaduse
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = dec_use_rs1 & (dec_rs1 == ex_rd);
  assign rs2_hit = dec_use_rs2 & (dec_rs2 == ex_rd);

  // Only a valid load in execute with a non-zero destination can stall decode.
  always_comb begin
    loaduse = id_valid & ex_valid & ex_read_mem & (ex_rd != '0) & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage valids, register enables and flushes with
// memory-wait freeze, branch-redirect flush and one-cycle load-use interlock.
module pipe_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int NUM_STAGES  = 5,   // at least 5
  parameter int REG_ADDR_W  = 5,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] dec_rs1,
  input  logic [REG_ADDR_W-1:0] dec_rs2,
  input  logic                  dec_use_rs1,
  input  logic                  dec_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_read_mem,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  input  logic                  redirect,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  bubble,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  mem_err
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  logic [NUM_STAGES-1:0] valid_reg;
  logic [NUM_STAGES-1:0] valid_next;
  logic [CNT_W-1:0]      stall_cnt_reg;
  logic [WAIT_W-1:0]     wait_cnt_reg;
  logic [WAIT_W-1:0]     wait_cnt_next;
  logic                  mem_err_reg;
  pipe_state_t           state_reg;
  pipe_state_t           state_next;
  logic                  loaduse;
  logic                  memwait;
  logic                  redir_go;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .id_valid    (valid_reg[STG_ID]),
    .ex_valid    (valid_reg[STG_EX]),
    .dec_rs1     (dec_rs1),
    .dec_rs2     (dec_rs2),
    .dec_use_rs1 (dec_use_rs1),
    .dec_use_rs2 (dec_use_rs2),
    .ex_rd       (ex_rd),
    .ex_read_mem (ex_read_mem),
    .loaduse     (loaduse)
  );

  // A redirect during a memory wait is deferred: the memory register is frozen,
  // so the branch stays in place and redirects once the access completes.
  assign memwait  = valid_reg[STG_MEM] & mem_req & ~mem_ready;
  assign redir_go = valid_reg[STG_MEM] & redirect & ~memwait;

  // Enables, flushes and bubble in priority order memwait > redirect > load-use.
  always_comb begin
    stage_en = '1;
    flush    = '0;
    bubble   = 1'b0;
    if (memwait) begin
      stage_en[STG_MEM:STG_IF] = '0;
    end else if (redir_go) begin
      flush[STG_EX:STG_IF] = '1;
    end else if (loaduse) begin
      stage_en[STG_ID:STG_IF] = '0;
      bubble                  = 1'b1;
    end
  end

  // A stage loads a valid token only if its upstream stage advanced unflushed;
  // a held or flushed upstream stage therefore inserts a bubble downstream.
  assign valid_next[STG_IF] = stage_en[STG_IF] | valid_reg[STG_IF];
  for (genvar gi = 1; gi < NUM_STAGES; gi++) begin : g_valid
    assign valid_next[gi] = stage_en[gi]
                          ? (valid_reg[gi-1] & stage_en[gi-1] & ~flush[gi-1])
                          : valid_reg[gi];
  end

  // Wait FSM next state; the entry cycle already counts as the first wait cycle.
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      RUN: begin
        wait_cnt_next = '0;
        if (memwait) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (memwait) begin
          if (wait_cnt_reg != WAIT_MAX) begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
          end
        end else begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // State registers: valids, FSM, wait/stall counters and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg     <= '0;
      state_reg     <= RUN;
      wait_cnt_reg  <= '0;
      stall_cnt_reg <= '0;
      mem_err_reg   <= 1'b0;
    end else begin
      valid_reg    <= valid_next;
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (!stage_en[STG_IF] && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (memwait && (wait_cnt_next == WAIT_MAX)) begin
        mem_err_reg <= 1'b1;
      end
    end
  end

  assign stage_valid = valid_reg;
  assign stall_cnt   = stall_cnt_reg;
  assign mem_err     = mem_err_reg;

endmodule
